// File: rtl/audio_pkg.sv
// Shared types for the I2S DAC path: sample type, frame geometry, controller states.
// Pure declarations, no logic and no timing.
package audio_pkg;
    localparam int SAMPLE_BITS = 16;
    localparam int FRAME_BITS  = 64;
    localparam int BIT_CNT_W   = $clog2(FRAME_BITS);

    typedef logic signed [SAMPLE_BITS-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;
endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK divider: toggles BCLK every BCLK_HALF cycles while run is high, held low otherwise.
// fall_evt is combinational and marks the cycle whose closing edge drives BCLK 1->0.
module i2s_clk_gen #(
    parameter int BCLK_HALF = 8
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic run,
    output logic BCLK,
    output logic fall_evt
);
    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             div_end;

    assign div_end  = run && (div_q == DIV_LAST);
    assign fall_evt = div_end && bclk_q;
    assign BCLK     = bclk_q;

    always_comb begin
        div_d  = '0;
        bclk_d = 1'b0;
        if (run) begin
            div_d  = div_end ? '0 : div_q + DIV_W'(1);
            bclk_d = div_end ? !bclk_q : bclk_q;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end
endmodule

// File: rtl/i2s_dac_controller.sv
// I2S transmitter for a stereo DAC with a one-pair holding buffer (valid/ready upstream).
// Left MSB appears one BCLK after the frame load; ready drops while the buffer is full.
module i2s_dac_controller
    import audio_pkg::*;
#(
    parameter int BCLK_HALF = 8,
    parameter int CNT_W     = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             enable,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [15:0]      leftSample,
    input  logic [15:0]      rightSample,
    output logic             BCLK,
    output logic             DACLRCK,
    output logic             DACDAT,
    output logic             frame_start,
    output logic             underrun,
    output logic [CNT_W-1:0] underrun_count
);
    localparam int HALF_W = BIT_CNT_W - 1;
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);

    state_e                   state_q, state_d;
    logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d, bit_next;
    logic                     first_q, first_d;
    logic                     buf_full_q, buf_full_d;
    sample_t                  buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [2*SAMPLE_BITS-1:0] sh_q, sh_d;
    logic                     lrck_q, lrck_d, dat_q, dat_d;
    logic                     fs_q, fs_d, ur_q, ur_d;
    logic [CNT_W-1:0]         ucnt_q, ucnt_d;

    logic run, fall_evt, wrap, stop_end, load_evt, xfer, data_slot;

    i2s_clk_gen #(.BCLK_HALF(BCLK_HALF)) u_clk_gen (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .run      (run),
        .BCLK     (BCLK),
        .fall_evt (fall_evt)
    );

    // The first fall after leaving IDLE is treated as a frame wrap so a load happens immediately.
    assign run      = (state_q != ST_IDLE);
    assign wrap     = fall_evt && (first_q || (bit_cnt_q == BIT_LAST));
    assign stop_end = wrap && (state_q == ST_STOP) && !enable;
    assign load_evt = wrap && !stop_end;
    assign bit_next = wrap ? '0 : bit_cnt_q + BIT_CNT_W'(1);
    assign data_slot = (bit_next[HALF_W-1:0] != '0) &&
                       (bit_next[HALF_W-1:0] <= HALF_W'(SAMPLE_BITS));

    assign sample_ready = run && (!buf_full_q || load_evt);
    assign xfer         = sample_valid && sample_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_RUN;
            ST_RUN:  if (!enable) state_d = ST_STOP;
            ST_STOP: begin
                if (stop_end)    state_d = ST_IDLE;
                else if (enable) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        first_d = first_q;
        if ((state_q == ST_IDLE) && enable) first_d = 1'b1;
        else if (fall_evt)                  first_d = 1'b0;
        bit_cnt_d = fall_evt ? bit_next : bit_cnt_q;
    end

    // Load takes the buffer as it stood before this edge; a same-cycle transfer refills it.
    always_comb begin
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        if (load_evt) buf_full_d = 1'b0;
        if (xfer) begin
            buf_full_d = 1'b1;
            buf_l_d    = sample_t'(leftSample);
            buf_r_d    = sample_t'(rightSample);
        end
    end

    always_comb begin
        sh_d   = sh_q;
        lrck_d = lrck_q;
        dat_d  = dat_q;
        if (fall_evt) begin
            lrck_d = bit_next[BIT_CNT_W-1];
            dat_d  = 1'b0;
            if (load_evt) begin
                sh_d = buf_full_q ? {buf_l_q, buf_r_q} : '0;
            end else if (data_slot) begin
                dat_d = sh_q[2*SAMPLE_BITS-1];
                sh_d  = {sh_q[2*SAMPLE_BITS-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        fs_d   = load_evt;
        ur_d   = load_evt && !buf_full_q;
        ucnt_d = ucnt_q;
        if (ur_d && (ucnt_q != '1)) ucnt_d = ucnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            first_q    <= 1'b0;
            buf_full_q <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            sh_q       <= '0;
            lrck_q     <= 1'b0;
            dat_q      <= 1'b0;
            fs_q       <= 1'b0;
            ur_q       <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            first_q    <= first_d;
            buf_full_q <= buf_full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            sh_q       <= sh_d;
            lrck_q     <= lrck_d;
            dat_q      <= dat_d;
            fs_q       <= fs_d;
            ur_q       <= ur_d;
            ucnt_q     <= ucnt_d;
        end
    end

    assign DACLRCK        = lrck_q;
    assign DACDAT         = dat_q;
    assign frame_start    = fs_q;
    assign underrun       = ur_q;
    assign underrun_count = ucnt_q;
endmodule

// File: tb/tb_i2s_dac_controller.sv
// Directed bench: stimulus pushes expected frames, a BCLK-decoding monitor pops and compares.
module tb_i2s_dac_controller;
    localparam int H         = 2;
    localparam int CW        = 2;
    localparam int FRAME_CYC = 64 * 2 * H;
    localparam int LOAD_LAT  = 2 * H + 1;

    logic          CLOCK_50 = 1'b0;
    logic          RESET = 1'b1, enable = 1'b0, sample_valid = 1'b0;
    logic [15:0]   leftSample = '0, rightSample = '0;
    logic          sample_ready, BCLK, DACLRCK, DACDAT, frame_start, underrun;
    logic [CW-1:0] underrun_count;

    int n_tests = 0, n_fail = 0;
    logic [31:0] exp_q[$];

    int   bit_idx = 0, cyc = 0, frames_done = 0, fs_cnt = 0, ur_cnt = 0;
    int   last_fs_cyc = 0, fs_gap = 0, last_rise_cyc = 0, rise_gap = 0;
    bit   in_frame = 1'b0;
    logic bclk_prev = 1'b0;
    logic [63:0] cap_dat = '0, cap_lr = '0;

    i2s_dac_controller #(.BCLK_HALF(H), .CNT_W(CW)) dut (
        .CLOCK_50       (CLOCK_50),
        .RESET          (RESET),
        .enable         (enable),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .leftSample     (leftSample),
        .rightSample    (rightSample),
        .BCLK           (BCLK),
        .DACLRCK        (DACLRCK),
        .DACDAT         (DACDAT),
        .frame_start    (frame_start),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_vec(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] v = '0;
        for (int i = 1; i <= 16; i++) begin
            v[i]      = l[16-i];
            v[32 + i] = r[16-i];
        end
        return v;
    endfunction

    task automatic check_frame();
        logic [31:0] p;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_unexpected: got dat=%h, expected no frame", cap_dat);
        end else begin
            p = exp_q.pop_front();
            check("frame_dat", cap_dat, exp_vec(p[31:16], p[15:0]));
            check("frame_lrck", cap_lr, 64'hFFFF_FFFF_0000_0000);
        end
    endtask

    // Monitor: bit index restarts at frame_start, advances on BCLK falls; data sampled on rises.
    always @(negedge CLOCK_50) begin
        cyc++;
        if (RESET) begin
            in_frame  = 1'b0;
            bclk_prev = 1'b0;
        end else begin
            if (underrun) ur_cnt++;
            if (frame_start) begin
                fs_cnt++;
                fs_gap      = cyc - last_fs_cyc;
                last_fs_cyc = cyc;
                in_frame    = 1'b1;
                bit_idx     = 0;
            end else if (bclk_prev && !BCLK) begin
                bit_idx++;
            end
            if (!bclk_prev && BCLK) begin
                rise_gap      = cyc - last_rise_cyc;
                last_rise_cyc = cyc;
                if (in_frame && bit_idx < 64) begin
                    cap_dat[bit_idx] = DACDAT;
                    cap_lr[bit_idx]  = DACLRCK;
                    if (bit_idx == 63) begin
                        check_frame();
                        in_frame = 1'b0;
                        frames_done++;
                    end
                end
            end
            bclk_prev = BCLK;
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        check("sb_drain", exp_q.size(), 0);
        RESET = 1'b1;
        enable = 1'b0;
        sample_valid = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_done < target && n < 4000) begin tick(); n++; end
        check("frames_done", frames_done, target);
    endtask

    task automatic wait_fs(input int target);
        int n = 0;
        while (fs_cnt < target && n < 2000) begin tick(); n++; end
        check("frame_starts", fs_cnt, target);
    endtask

    task automatic wait_bit(input int b);
        int n = 0;
        while (!(in_frame && bit_idx == b) && n < 1000) begin tick(); n++; end
        check("reach_bit", bit_idx, b);
    endtask

    task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
        int n = 0;
        sample_valid = 1'b1;
        leftSample   = l;
        rightSample  = r;
        while (!sample_ready && n < 2000) begin tick(); n++; end
        check("send_ready", sample_ready, 1);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic time_first_load(input int exp_lat);
        int n = 0;
        enable = 1'b1;
        while (!frame_start && n < 100) begin tick(); n++; end
        check("first_load_lat", n, exp_lat);
    endtask

    initial begin
        int bf, bs, bu;
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bf, bs, bu;
        tick();
        do_reset();
        check("rst_bclk", BCLK, 0);
        check("rst_lrck", DACLRCK, 0);
        check("rst_dat", DACDAT, 0);
        check("rst_ready", sample_ready, 0);
        check("rst_fs", frame_start, 0);
        check("rst_ur", underrun, 0);
        check("rst_ucnt", underrun_count, 0);

        // Basic frame, timing and latency
        bf = frames_done; bu = ur_cnt;
        exp_q.push_back({16'hA5C3, 16'h0F0F});
        exp_q.push_back(32'h0);
        fork
            time_first_load(LOAD_LAT);
            send_pair(16'hA5C3, 16'h0F0F);
        join
        wait_frames(bf + 2);
        check("bclk_period", rise_gap, 2 * H);
        check("frame_period", fs_gap, FRAME_CYC);
        check("ur_basic", ur_cnt - bu, 1);
        do_reset();

        // Underruns and counter saturation
        bf = frames_done; bs = fs_cnt; bu = ur_cnt;
        repeat (5) exp_q.push_back(32'h0);
        enable = 1'b1;
        wait_fs(bs + 1);
        check("ucnt_1", underrun_count, 1);
        wait_fs(bs + 3);
        check("ur_pulses_3", ur_cnt - bu, 3);
        check("ucnt_3", underrun_count, 3);
        wait_fs(bs + 5);
        check("ur_pulses_5", ur_cnt - bu, 5);
        check("ucnt_sat", underrun_count, 3);
        wait_frames(bf + 5);
        do_reset();

        // Continuous valid: one transfer per frame, in order
        bf = frames_done; bu = ur_cnt;
        for (int i = 1; i <= 4; i++) exp_q.push_back({16'(i), 16'h8000 | 16'(i)});
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send_pair(16'(i), 16'h8000 | 16'(i));
            check("xfer_at_load", frame_start, (i > 1));
        end
        wait_frames(bf + 4);
        check("ur_stream", ur_cnt - bu, 0);
        do_reset();

        // Stop mid-frame, buffer retained across IDLE
        bf = frames_done; bs = fs_cnt;
        exp_q.push_back({16'h1234, 16'h5678});
        exp_q.push_back({16'hBEEF, 16'hCAFE});
        enable = 1'b1;
        send_pair(16'h1234, 16'h5678);
        wait_fs(bs + 1);
        wait_bit(10);
        enable = 1'b0;
        send_pair(16'hBEEF, 16'hCAFE);
        wait_frames(bf + 1);
        repeat (3 * H + 5) tick();
        check("stop_bclk", BCLK, 0);
        check("stop_lrck", DACLRCK, 0);
        check("stop_dat", DACDAT, 0);
        check("stop_ready", sample_ready, 0);
        check("stop_falls", bit_idx, 64);
        check("stop_no_fs", fs_cnt, bs + 1);
        time_first_load(LOAD_LAT);
        check("resume_no_ur", underrun, 0);
        wait_frames(bf + 2);
        do_reset();

        // Enable re-raised during STOP: no gap
        bs = fs_cnt; bu = ur_cnt;
        exp_q.push_back({16'h7E81, 16'h0180});
        enable = 1'b1;
        send_pair(16'h7E81, 16'h0180);
        wait_fs(bs + 1);
        wait_bit(10);
        enable = 1'b0;
        wait_bit(40);
        enable = 1'b1;
        wait_fs(bs + 2);
        check("rerun_gap", fs_gap, FRAME_CYC);
        check("rerun_ur", ur_cnt - bu, 1);
        do_reset();

        // Reset mid-frame with a full buffer
        bf = frames_done; bs = fs_cnt;
        enable = 1'b1;
        wait_fs(bs + 1);
        send_pair(16'h3C3C, 16'hC3C3);
        wait_bit(20);
        check("pre_rst_ucnt", underrun_count, 1);
        RESET = 1'b1;
        tick();
        check("mid_rst_bclk", BCLK, 0);
        check("mid_rst_lrck", DACLRCK, 0);
        check("mid_rst_dat", DACDAT, 0);
        check("mid_rst_ready", sample_ready, 0);
        check("mid_rst_fs", frame_start, 0);
        check("mid_rst_ur", underrun, 0);
        check("mid_rst_ucnt", underrun_count, 0);
        RESET = 1'b0;
        exp_q.push_back(32'h0);
        time_first_load(LOAD_LAT);
        check("post_rst_ur", underrun, 1);
        wait_frames(bf + 1);
        do_reset();

        // Pair offered exactly in the load-event cycle with buffer empty
        bf = frames_done; bu = ur_cnt;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back({16'h0102, 16'h0304});
        time_first_load(LOAD_LAT);
        repeat (FRAME_CYC - 1) tick();
        sample_valid = 1'b1;
        leftSample   = 16'h0102;
        rightSample  = 16'h0304;
        check("ready_at_load", sample_ready, 1);
        tick();
        sample_valid = 1'b0;
        check("late_pair_ur", underrun, 1);
        check("late_pair_fs", frame_start, 1);
        wait_frames(bf + 3);
        check("late_pair_ur_total", ur_cnt - bu, 2);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_dac_controller.md
I2S_DAC_CONTROLLER -- requirements
Module: i2s_dac_controller

Interface
REQ-001 SHALL have parameter BCLK_HALF, default 8, giving CLOCK_50 cycles per BCLK half-period (3.125 MHz BCLK, about 48.8 kHz frame).
REQ-002 SHALL have parameter CNT_W, default 8, giving the underrun counter width.
REQ-003 CLOCK_50  in  1  sole clock; all logic on the rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  run request; sampled every cycle.
REQ-006 sample_valid  in  1  upstream stereo pair present.
REQ-007 sample_ready  out  1  controller accepts a pair this cycle.
REQ-008 leftSample, rightSample  in  16 each  signed two's-complement samples.
REQ-009 BCLK  out  1  bit clock to codec.
REQ-010 DACLRCK  out  1  word select; 0 = left, 1 = right.
REQ-011 DACDAT  out  1  serial data, MSB first.
REQ-012 frame_start  out  1  one-cycle pulse at each frame load.
REQ-013 underrun  out  1  one-cycle pulse when a frame loads with no pair buffered.
REQ-014 underrun_count  out  CNT_W  saturating count of underruns.

Function
REQ-015 SHALL hold a divider counter 0..BCLK_HALF-1; BCLK SHALL toggle when the counter equals BCLK_HALF-1, and only in RUN or STOP.
REQ-016 SHALL define a "fall event" as the cycle in which BCLK is driven 1->0; all bit-counter, DACLRCK and DACDAT updates SHALL occur only on fall events.
REQ-017 SHALL keep a 6-bit bit counter (64 BCLK per frame) that increments on each fall event and wraps 63->0.
REQ-018 At bit count 0..31, DACLRCK SHALL be 0; at bit count 32..63, DACLRCK SHALL be 1.
REQ-019 Data placement (I2S, one-BCLK delay) SHALL be:
- bit 1..16: left bits 15..0;
- bit 33..48: right bits 15..0;
- all other bit positions: DACDAT = 0.
REQ-020 On the fall event that wraps the counter to 0 (the "load event"), a full holding buffer SHALL be copied into the shift registers and frame_start SHALL pulse.
REQ-021 At a load event with the buffer empty, the shift registers SHALL load zeros, underrun SHALL pulse, and underrun_count SHALL increment, saturating at all-ones.
REQ-022 SHALL hold a one-entry holding buffer; sample_ready SHALL equal (state != IDLE) and (buffer empty, or load event this cycle).
REQ-023 A transfer SHALL occur when sample_valid and sample_ready are both high; that pair SHALL be used at the next load event, never the current one.
REQ-024 If a load event and a transfer coincide, the old pair SHALL go to the shift registers and the new pair SHALL enter the buffer.
REQ-025 If the buffer is empty at a load event, a pair accepted in that same cycle SHALL still produce an underrun.
REQ-026 FSM states SHALL be IDLE, RUN, STOP:
- IDLE -> RUN when enable=1; the divider and bit counter start from 0 and the first fall event is the load event;
- RUN -> STOP when enable=0;
- STOP -> IDLE at the end of bit 63, with BCLK low;
- STOP -> RUN if enable returns to 1 before then (the frame is not restarted).
REQ-027 In IDLE, BCLK, DACLRCK and DACDAT SHALL be 0, and the buffer contents SHALL be retained.
REQ-028 Latency from the load event to the left MSB on DACDAT SHALL be one BCLK period.

Reset
REQ-029 On RESET=1 at a clock edge, the following SHALL hold after that edge, including when reset arrives mid-frame:
- state IDLE;
- BCLK=0, DACLRCK=0, DACDAT=0;
- sample_ready=0, frame_start=0, underrun=0;
- underrun_count=0;
- buffer empty;
- all counters 0.
REQ-030 RESET SHALL take priority over enable and sample_valid.

Structure
REQ-031 Package audio_pkg SHALL define sample_t (signed 16-bit), SAMPLE_BITS=16, FRAME_BITS=64, and the FSM state enum.
REQ-032 The divider and fall-event strobe SHALL be one sub-module, i2s_clk_gen (outputs BCLK and fall_evt, input run); all other logic SHALL be in the top level.

Verification
REQ-033 BCLK_HALF=2, enable=1, pair left=16'hA5C3, right=16'h0F0F supplied before the first load event -> DACDAT bits 1..16 = A5C3, bits 33..48 = 0F0F, all others 0; BCLK period 4 cycles; frame 256 cycles.
REQ-034 No sample_valid for 3 frames -> 3 underrun pulses, underrun_count=3, DACDAT all 0; with CNT_W=2 and 5 frames -> count saturates at 3.
REQ-035 sample_valid held high continuously -> exactly one transfer per frame, each at the load event after the buffer fills; no pair dropped or duplicated (check sequence 1,2,3,4).
REQ-036 enable dropped at bit 10 -> frame completes through bit 63, then IDLE with BCLK=0; enable re-raised at bit 40 of STOP -> no gap in BCLK.
REQ-037 RESET asserted at bit 20 mid-frame -> all outputs at reset values on the next edge; after release with enable=1, the first load event occurs 2*BCLK_HALF-1 cycles after leaving IDLE.
REQ-038 Buffer empty and sample_valid asserted exactly in the load-event cycle -> underrun pulses, pair accepted, and that pair is transmitted in the following frame.
